fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter INS_SIZE, default 32, instruction word width in bits.
REQ-002 Parameter INS_LENGTH, default 256, number of valid instruction memory locations.
REQ-003 Parameter COUNTSIZE, default 8, program-count width in bits.
REQ-004 Parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that stops fetch.
REQ-005 Parameter LOOP_CHECK, default 1, enables repeated-count detection when 1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-008 start  input  1  pulse that begins or restarts fetching at count 0.
REQ-009 currentCount  output  COUNTSIZE  address presented to instruction memory.
REQ-010 memDone  input  1  instruction memory reports that instrIn is valid for currentCount.
REQ-011 instrIn  input  INS_SIZE  instruction word from memory.
REQ-012 instrOut  output  INS_SIZE  registered instruction handed to decode.
REQ-013 instrValid  output  1  instrOut is valid and awaiting acceptance.
REQ-014 instrReady  input  1  decode accepts instrOut this cycle.
REQ-015 stall  input  1  freezes the count advance while high.
REQ-016 branchValid  input  1  next count is to be taken from branchTarget.
REQ-017 branchTarget  input  COUNTSIZE  branch destination count.
REQ-018 halted  output  1  fetch has stopped (halt word or error).
REQ-019 errorCode  output  2  0 none, 1 count out of range, 2 loop detected, 3 reserved and never driven.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, ISSUE, HALT and ERROR.
REQ-021 IDLE: hold currentCount=0 and instrValid=0; start=1 -> FETCH.
REQ-022 FETCH: hold currentCount; memDone=1 -> register instrIn into instrOut, set instrValid=1 on the next edge, go to ISSUE.
REQ-023 FETCH SHALL wait indefinitely while memDone=0, with no timeout.
REQ-024 If the captured instrIn equals HALT_WORD, the block SHALL go to HALT instead of ISSUE, with instrValid=0 and halted=1.
REQ-025 ISSUE: instrValid and instrOut SHALL stay stable until an edge where instrReady=1 and stall=0 (acceptance).
REQ-026 On acceptance the next count SHALL be branchTarget if branchValid=1, else currentCount+1, computed COUNTSIZE+1 bits wide.
REQ-027 branchValid and branchTarget SHALL be sampled only on the acceptance edge and ignored on every other edge.
REQ-028 If stall=1 and branchValid=1 occur together, stall SHALL win and the branch SHALL be neither taken nor stored; the source holds it.
REQ-029 If the next count is >= INS_LENGTH, including a carry out of COUNTSIZE bits, the block SHALL go to ERROR with errorCode=1, leave currentCount unchanged and drive instrValid=0.
REQ-030 The block SHALL keep the last three accepted counts in a history; with LOOP_CHECK=1, a next count equal to the oldest entry while all three entries are valid -> ERROR with errorCode=2.
REQ-031 History entries SHALL be marked invalid on reset and on start, so the loop check is suppressed until three acceptances have occurred.
REQ-032 A legal next count SHALL update currentCount, clear instrValid and enter FETCH, giving a one-cycle bubble per instruction.
REQ-033 HALT: halted=1; start=1 -> currentCount=0, history cleared, halted=0, go to FETCH.
REQ-034 ERROR: halted=1 and errorCode held; only reset leaves ERROR, and start is ignored.
REQ-035 start in FETCH or ISSUE SHALL abort the current fetch, drop instrValid, set currentCount=0 and enter FETCH.
REQ-036 Outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-037 While reset=0 the block SHALL be in IDLE with currentCount=0, instrOut=0, instrValid=0, halted=0, errorCode=0 and history invalid.
REQ-038 Reset asserted mid-operation, in any state including ERROR, SHALL abandon all activity immediately.
REQ-039 After reset is released the block SHALL stay in IDLE until start=1.

Verification
REQ-040 Sequential fetch: start, memDone=1, instrReady=1, memory words 0..4 distinct and non-halt -> currentCount 0,1,2,3,4, each instrOut delivered with one bubble cycle.
REQ-041 Stall and branch: at count 2, stall=1 for 3 cycles with branchValid=1 and branchTarget=8, then stall=0 with branch held -> instrValid stays high throughout, then currentCount=8.
REQ-042 Halt: word at count 3 equals HALT_WORD -> halted=1, errorCode=0, instrValid=0; start -> currentCount=0, halted=0.
REQ-043 Range: INS_LENGTH=16, branch to 16 -> ERROR, errorCode=1; COUNTSIZE=8, INS_LENGTH=256, accept at count 255 -> errorCode=1, no wrap to 0.
REQ-044 Loop: branch sequence 4->5->6->4 with LOOP_CHECK=1 -> errorCode=2; the same sequence with LOOP_CHECK=0 continues fetching.
REQ-045 Async reset: drive reset low between clock edges while in ISSUE with instrValid=1 -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose: walks an instruction memory one count at a time. It presents an
// address, waits for the memory to answer, registers the word and offers it
// to decode. When decode accepts the word, the next count is either the
// sequential successor or a branch target. Fetch stops on a halt word, on a
// count that leaves the valid memory range, or on a detected three-count loop.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         begin / restart fetching at count 0 (ignored in ERROR)
//   currentCount  address presented to instruction memory
//   memDone       memory reports instrIn is valid for currentCount
//   instrIn       instruction word from memory
//   instrOut      registered instruction handed to decode
//   instrValid    instrOut is valid and waiting for acceptance
//   instrReady    decode accepts instrOut this cycle
//   stall         freezes the count advance while high
//   branchValid   take next count from branchTarget (sampled on acceptance)
//   branchTarget  branch destination count
//   halted        fetch has stopped (halt word or error)
//   errorCode     0 none, 1 count out of range, 2 loop detected
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                  INS_SIZE   = 32,
    parameter int                  INS_LENGTH = 256,
    parameter int                  COUNTSIZE  = 8,
    parameter logic [INS_SIZE-1:0] HALT_WORD  = 32'hFFFFFFFF,
    parameter int                  LOOP_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [COUNTSIZE-1:0] currentCount,
    input  logic                 memDone,
    input  logic [INS_SIZE-1:0]  instrIn,
    output logic [INS_SIZE-1:0]  instrOut,
    output logic                 instrValid,
    input  logic                 instrReady,
    input  logic                 stall,
    input  logic                 branchValid,
    input  logic [COUNTSIZE-1:0] branchTarget,
    output logic                 halted,
    output logic [1:0]           errorCode
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [31:0] COUNT_LIMIT = INS_LENGTH;

    logic [2:0]           r_state;
    logic [COUNTSIZE-1:0] r_count;
    logic [INS_SIZE-1:0]  r_instr;
    logic                 r_valid;
    logic                 r_halted;
    logic [1:0]           r_errorCode;

    // The count being accepted right now is the newest of the three history
    // entries; these two registers hold the two acceptances before it.
    logic [COUNTSIZE-1:0] r_histPrev;
    logic [COUNTSIZE-1:0] r_histOld;
    logic                 r_histPrevValid;
    logic                 r_histOldValid;

    logic                 w_accept;
    logic [COUNTSIZE:0]   w_nextCount;
    logic [31:0]          w_nextWide;
    logic                 w_outOfRange;
    logic                 w_loop;
    logic                 w_isHalt;

    assign w_accept    = instrReady & ~stall;

    // One extra bit so that an increment past the top of the count range is
    // seen as out of range instead of wrapping back to zero.
    assign w_nextCount = branchValid ? {1'b0, branchTarget}
                                     : ({1'b0, r_count} + {{COUNTSIZE{1'b0}}, 1'b1});
    assign w_nextWide   = 32'(w_nextCount);
    assign w_outOfRange = (w_nextWide >= COUNT_LIMIT);

    // With the current count pushed, the oldest of three entries is r_histOld.
    assign w_loop = (LOOP_CHECK != 0) && r_histPrevValid && r_histOldValid
                    && (w_nextCount == {1'b0, r_histOld});

    assign w_isHalt = (instrIn == HALT_WORD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_instr         <= '0;
            r_valid         <= 1'b0;
            r_halted        <= 1'b0;
            r_errorCode     <= 2'd0;
            r_histPrev      <= '0;
            r_histOld       <= '0;
            r_histPrevValid <= 1'b0;
            r_histOldValid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state         <= S_FETCH;
                        r_count         <= '0;
                        r_histPrevValid <= 1'b0;
                        r_histOldValid  <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (start) begin
                        r_count         <= '0;
                        r_valid         <= 1'b0;
                        r_histPrevValid <= 1'b0;
                        r_histOldValid  <= 1'b0;
                    end else if (memDone) begin
                        r_instr <= instrIn;
                        if (w_isHalt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_valid <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (start) begin
                        r_state         <= S_FETCH;
                        r_count         <= '0;
                        r_valid         <= 1'b0;
                        r_histPrevValid <= 1'b0;
                        r_histOldValid  <= 1'b0;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                        if (w_outOfRange) begin
                            r_state     <= S_ERROR;
                            r_halted    <= 1'b1;
                            r_errorCode <= 2'd1;
                        end else if (w_loop) begin
                            r_state     <= S_ERROR;
                            r_halted    <= 1'b1;
                            r_errorCode <= 2'd2;
                        end else begin
                            r_state         <= S_FETCH;
                            r_count         <= w_nextCount[COUNTSIZE-1:0];
                            r_histOld       <= r_histPrev;
                            r_histOldValid  <= r_histPrevValid;
                            r_histPrev      <= r_count;
                            r_histPrevValid <= 1'b1;
                        end
                    end
                end

                S_HALT: begin
                    if (start) begin
                        r_state         <= S_FETCH;
                        r_count         <= '0;
                        r_halted        <= 1'b0;
                        r_histPrevValid <= 1'b0;
                        r_histOldValid  <= 1'b0;
                    end
                end

                // Only reset leaves ERROR.
                S_ERROR: begin
                    r_state <= S_ERROR;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign currentCount = r_count;
    assign instrOut     = r_instr;
    assign instrValid   = r_valid;
    assign halted       = r_halted;
    assign errorCode    = r_errorCode;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Purpose: self-checking bench for fetch_sequencer. Two instances share all
// control inputs: dutA uses the default parameters, dutB uses a 16-entry
// memory range with loop detection disabled. Each has its own memory read
// port into a common memory array.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] HALTW = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        memDone;
    logic        instrReady;
    logic        stall;
    logic        branchValid;
    logic [7:0]  branchTarget;

    logic [7:0]  countA, countB;
    logic [31:0] instrInA, instrInB, instrOutA, instrOutB;
    logic        validA, validB, haltedA, haltedB;
    logic [1:0]  errA, errB;

    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference model state for dutA
    int          expCount;
    bit          expIdle, expValid, expHalted;
    int          expErr;
    logic [31:0] expOut;
    int          hist[$];

    always #5 clk = ~clk;

    assign instrInA = mem[countA];
    assign instrInB = mem[countB];

    fetch_sequencer dutA (
        .clk(clk), .reset(reset), .start(start), .currentCount(countA),
        .memDone(memDone), .instrIn(instrInA), .instrOut(instrOutA),
        .instrValid(validA), .instrReady(instrReady), .stall(stall),
        .branchValid(branchValid), .branchTarget(branchTarget),
        .halted(haltedA), .errorCode(errA)
    );

    fetch_sequencer #(.INS_LENGTH(16), .LOOP_CHECK(0)) dutB (
        .clk(clk), .reset(reset), .start(start), .currentCount(countB),
        .memDone(memDone), .instrIn(instrInB), .instrOut(instrOutB),
        .instrValid(validB), .instrReady(instrReady), .stall(stall),
        .branchValid(branchValid), .branchTarget(branchTarget),
        .halted(haltedB), .errorCode(errB)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic initMem();
        for (int i = 0; i < 256; i++)
            mem[i] = {8'(i), 23'($urandom), 1'b0};
    endtask

    task automatic modelReset();
        expCount  = 0;
        expIdle   = 1'b1;
        expValid  = 1'b0;
        expHalted = 1'b0;
        expErr    = 0;
        expOut    = '0;
        hist.delete();
    endtask

    task automatic doReset();
        reset = 1'b0; start = 1'b0; memDone = 1'b0; instrReady = 1'b0;
        stall = 1'b0; branchValid = 1'b0; branchTarget = '0;
        step();
        step();
        reset = 1'b1;
        modelReset();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int nxt;
        if (expErr != 0) begin
        end else if (start) begin
            expIdle = 1'b0; expCount = 0; expValid = 1'b0; expHalted = 1'b0;
            hist.delete();
        end else if (expIdle || expHalted) begin
        end else if (!expValid) begin
            if (memDone) begin
                expOut = mem[expCount];
                if (expOut == HALTW) expHalted = 1'b1;
                else                 expValid  = 1'b1;
            end
        end else if (instrReady && !stall) begin
            nxt = branchValid ? int'(branchTarget) : expCount + 1;
            hist.push_back(expCount);
            if (hist.size() > 3) void'(hist.pop_front());
            expValid = 1'b0;
            if (nxt >= 256) begin
                expErr = 1; expHalted = 1'b1;
            end else if (hist.size() == 3 && nxt == hist[0]) begin
                expErr = 2; expHalted = 1'b1;
            end else begin
                expCount = nxt;
            end
        end
    endtask

    task automatic waitValidA(input int maxCycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            if (validA) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_valid: instrValid=%0b after %0d cycles, required 1", validA, maxCycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; memDone = 1'b1; instrReady = 1'b1;
        stall = 1'b0; branchValid = 1'b0; branchTarget = '0;
        step();
        checks++;
        if ({countA, instrOutA, validA, haltedA, errA} !== 44'd0) begin
            failures++;
            $display("FAIL reset_state_A: got %0h required 0", {countA, instrOutA, validA, haltedA, errA});
        end
        checks++;
        if ({countB, instrOutB, validB, haltedB, errB} !== 44'd0) begin
            failures++;
            $display("FAIL reset_state_B: got %0h required 0", {countB, instrOutB, validB, haltedB, errB});
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({countA, validA, haltedA} !== 10'd0) begin
            failures++;
            $display("FAIL idle_hold: count=%0d valid=%0b halted=%0b required 0/0/0", countA, validA, haltedA);
        end
    endtask

    task automatic test_sequential();
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (countA !== 8'd0 || validA !== 1'b0) begin
            failures++;
            $display("FAIL seq_first_fetch: count=%0d valid=%0b required 0/0", countA, validA);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (validA !== 1'b1 || countA !== 8'(k) || instrOutA !== mem[k]) begin
                failures++;
                $display("FAIL seq_issue_%0d: valid=%0b count=%0d instr=%08h required 1/%0d/%08h",
                         k, validA, countA, instrOutA, k, mem[k]);
            end
            step();
            checks++;
            if (validA !== 1'b0 || countA !== 8'(k + 1)) begin
                failures++;
                $display("FAIL seq_bubble_%0d: valid=%0b count=%0d required 0/%0d", k, validA, countA, k + 1);
            end
        end
    endtask

    task automatic test_stall_branch();
        bit found;
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (validA && countA == 8'd2) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_reach_2: count=%0d valid=%0b required 2/1", countA, validA);
        end
        stall = 1'b1; branchValid = 1'b1; branchTarget = 8'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (validA !== 1'b1 || countA !== 8'd2 || instrOutA !== mem[2]) begin
                failures++;
                $display("FAIL stall_hold_%0d: valid=%0b count=%0d instr=%08h required 1/2/%08h",
                         i, validA, countA, instrOutA, mem[2]);
            end
        end
        stall = 1'b0;
        step();
        branchValid = 1'b0;
        checks++;
        if (countA !== 8'd8 || validA !== 1'b0) begin
            failures++;
            $display("FAIL branch_taken: count=%0d valid=%0b required 8/0", countA, validA);
        end
        step();
        checks++;
        if (validA !== 1'b1 || instrOutA !== mem[8]) begin
            failures++;
            $display("FAIL branch_fetch: valid=%0b instr=%08h required 1/%08h", validA, instrOutA, mem[8]);
        end
    endtask

    task automatic test_halt();
        bit seen;
        mem[3] = HALTW;
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (haltedA) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || countA !== 8'd3 || errA !== 2'd0 || validA !== 1'b0) begin
            failures++;
            $display("FAIL halt_word: halted=%0b count=%0d err=%0d valid=%0b required 1/3/0/0",
                     haltedA, countA, errA, validA);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (countA !== 8'd0 || haltedA !== 1'b0 || validA !== 1'b0) begin
            failures++;
            $display("FAIL halt_restart: count=%0d halted=%0b valid=%0b required 0/0/0", countA, haltedA, validA);
        end
        step();
        checks++;
        if (validA !== 1'b1 || instrOutA !== mem[0]) begin
            failures++;
            $display("FAIL halt_refetch: valid=%0b instr=%08h required 1/%08h", validA, instrOutA, mem[0]);
        end
        initMem();
    endtask

    task automatic test_range();
        // dutB has 16 locations: a branch to 16 is out of range
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        waitValidA(10);
        branchValid = 1'b1; branchTarget = 8'd16;
        step();
        branchValid = 1'b0;
        checks++;
        if (errB !== 2'd1 || haltedB !== 1'b1 || validB !== 1'b0 || countB !== 8'd0) begin
            failures++;
            $display("FAIL range_B_16: err=%0d halted=%0b valid=%0b count=%0d required 1/1/0/0",
                     errB, haltedB, validB, countB);
        end
        checks++;
        if (errA !== 2'd0 || countA !== 8'd16) begin
            failures++;
            $display("FAIL range_A_16: err=%0d count=%0d required 0/16", errA, countA);
        end
    endtask

    task automatic test_wrap();
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        waitValidA(10);
        branchValid = 1'b1; branchTarget = 8'd255;
        step();
        branchValid = 1'b0;
        checks++;
        if (countA !== 8'd255) begin
            failures++;
            $display("FAIL wrap_reach_255: count=%0d required 255", countA);
        end
        waitValidA(10);
        step();
        checks++;
        if (errA !== 2'd1 || countA !== 8'd255 || validA !== 1'b0 || haltedA !== 1'b1) begin
            failures++;
            $display("FAIL wrap_error: err=%0d count=%0d valid=%0b halted=%0b required 1/255/0/1",
                     errA, countA, validA, haltedA);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (errA !== 2'd1 || countA !== 8'd255 || haltedA !== 1'b1) begin
            failures++;
            $display("FAIL error_ignores_start: err=%0d count=%0d halted=%0b required 1/255/1",
                     errA, countA, haltedA);
        end
    endtask

    task automatic test_loop();
        int targets[4] = '{4, 5, 6, 4};
        doReset();
        memDone = 1'b1; instrReady = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        foreach (targets[i]) begin
            waitValidA(10);
            branchValid = 1'b1; branchTarget = 8'(targets[i]);
            step();
            branchValid = 1'b0;
        end
        checks++;
        if (errA !== 2'd2 || haltedA !== 1'b1 || validA !== 1'b0 || countA !== 8'd6) begin
            failures++;
            $display("FAIL loop_A: err=%0d halted=%0b valid=%0b count=%0d required 2/1/0/6",
                     errA, haltedA, validA, countA);
        end
        checks++;
        if (errB !== 2'd0 || haltedB !== 1'b0 || countB !== 8'd4) begin
            failures++;
            $display("FAIL loop_B_continue: err=%0d halted=%0b count=%0d required 0/0/4", errB, haltedB, countB);
        end
        step();
        checks++;
        if (validB !== 1'b1 || instrOutB !== mem[4]) begin
            failures++;
            $display("FAIL loop_B_fetch: valid=%0b instr=%08h required 1/%08h", validB, instrOutB, mem[4]);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        memDone = 1'b1; instrReady = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (validA !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_issue: valid=%0b required 1", validA);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({countA, instrOutA, validA, haltedA, errA} !== 44'd0) begin
            failures++;
            $display("FAIL async_reset: got %0h required 0", {countA, instrOutA, validA, haltedA, errA});
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (countA !== 8'd0 || validA !== 1'b0 || haltedA !== 1'b0) begin
            failures++;
            $display("FAIL async_stay_idle: count=%0d valid=%0b halted=%0b required 0/0/0", countA, validA, haltedA);
        end
    endtask

    task automatic test_random();
        int r;
        int errCycles;
        initMem();
        for (int i = 0; i < 3; i++) mem[$urandom_range(1, 15)] = HALTW;
        doReset();
        errCycles = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (expErr != 0) begin
                errCycles++;
                if (errCycles > 4) begin
                    doReset();
                    errCycles = 0;
                end
            end
            start        = expIdle || ($urandom_range(0, 49) == 0);
            memDone      = ($urandom_range(0, 2) != 0);
            instrReady   = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            branchValid  = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 7);
            if (r < 6)       branchTarget = 8'($urandom_range(0, 7));
            else if (r == 6) branchTarget = 8'd255;
            else             branchTarget = 8'($urandom_range(0, 255));
            modelStep();
            step();
            checks++;
            if ({countA, validA, haltedA, errA} !== {8'(expCount), expValid, expHalted, 2'(expErr)}) begin
                failures++;
                $display("FAIL random_state cyc%0d: count=%0d valid=%0b halted=%0b err=%0d required %0d/%0b/%0b/%0d",
                         cyc, countA, validA, haltedA, errA, expCount, expValid, expHalted, expErr);
            end
            if (expValid) begin
                checks++;
                if (instrOutA !== expOut) begin
                    failures++;
                    $display("FAIL random_instr cyc%0d: instr=%08h required %08h", cyc, instrOutA, expOut);
                end
            end
        end
        initMem();
    endtask

    initial begin
        initMem();
        test_reset();
        test_sequential();
        test_stall_branch();
        test_halt();
        test_range();
        test_wrap();
        test_loop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
